branch_redirect_ctrl: RTL and testbench

Branch resolution and PC-redirect sequencer for the 5-stage RISC-V core, located at the EX stage beside the ALU. It instantiates branch_decider, which evaluates the ALU flags for the EX-stage instruction. On a taken branch or jump it squashes the younger IF/ID instructions, hands the target PC to the fetch unit over a valid/ready handshake, and masks late wrong-path fetches. It also keeps branch and taken-branch performance counters.

---
 rtl/branch_redirect_ctrl.sv | 144 ++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch resolution and PC-redirect sequencer: squashes younger stages, hands the
// target to fetch over valid/ready, masks late wrong-path fetches and counts branches.

module branch_decider (
  input  logic [2:0] i_branch_type,
  input  logic       i_zero,
  input  logic       i_neg,
  input  logic       i_c_out,
  input  logic       i_over,
  output logic       o_taken
);

  // Flags come from a - b; c_out set means no borrow, i.e. a >= b unsigned.
  always_comb begin
    o_taken = 1'b0;
    case (i_branch_type)
      3'd1:    o_taken = i_zero;
      3'd2:    o_taken = ~i_zero;
      3'd3:    o_taken = i_neg ^ i_over;
      3'd4:    o_taken = ~(i_neg ^ i_over);
      3'd5:    o_taken = ~i_c_out;
      3'd6:    o_taken = i_c_out;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

module branch_redirect_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [2:0]       ex_branch_type,
  input  logic             ex_jump,
  input  logic             zero,
  input  logic             neg,
  input  logic             c_out,
  input  logic             over,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             ex_stall,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam int unsigned SqW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StRedir, StSquash} state_e;

  state_e           r_state, w_state_nxt;
  logic [SqW-1:0]   r_sq_cnt, w_sq_cnt_nxt;
  logic [XLEN-1:0]  r_redirect_pc;
  logic [CNT_W-1:0] r_branch_cnt, r_taken_cnt;
  logic             w_cond_taken, w_taken, w_counted, w_is_branch;

  branch_decider u_decider (
    .i_branch_type (ex_branch_type),
    .i_zero        (zero),
    .i_neg         (neg),
    .i_c_out       (c_out),
    .i_over        (over),
    .o_taken       (w_cond_taken)
  );

  // Gated by rst_n so the combinational flushes stay low while reset is held.
  assign w_is_branch = (ex_branch_type != 3'd0) && (ex_branch_type != 3'd7);
  assign w_taken     = rst_n & ex_valid & (ex_jump | w_cond_taken);
  assign w_counted   = rst_n & ex_valid & (ex_jump | w_is_branch);

  always_comb begin
    w_state_nxt    = r_state;
    w_sq_cnt_nxt   = r_sq_cnt;
    redirect_valid = 1'b0;
    flush_if       = 1'b0;
    flush_id       = 1'b0;
    ex_stall       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_taken) begin
          flush_if    = 1'b1;
          flush_id    = 1'b1;
          w_state_nxt = StRedir;
        end
      end
      StRedir: begin
        redirect_valid = 1'b1;
        ex_stall       = 1'b1;
        flush_if       = 1'b1;
        if (redirect_ready) begin
          if (FLUSH_CYCLES == 0) begin
            w_state_nxt = StIdle;
          end else begin
            w_sq_cnt_nxt = SqW'(FLUSH_CYCLES);
            w_state_nxt  = StSquash;
          end
        end
      end
      StSquash: begin
        flush_if     = 1'b1;
        w_sq_cnt_nxt = r_sq_cnt - SqW'(1);
        if (r_sq_cnt == SqW'(1)) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_sq_cnt      <= '0;
      r_redirect_pc <= '0;
      r_branch_cnt  <= '0;
      r_taken_cnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sq_cnt <= w_sq_cnt_nxt;
      // Resolution and counting happen only in IDLE; later EX slots are wrong-path bubbles.
      if (r_state == StIdle) begin
        if (w_taken) begin
          r_redirect_pc <= {ex_target[XLEN-1:1], 1'b0};
          r_taken_cnt   <= r_taken_cnt + CNT_W'(1);
        end
        if (w_counted) begin
          r_branch_cnt <= r_branch_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign redirect_pc  = r_redirect_pc;
  assign branch_count = r_branch_cnt;
  assign taken_count  = r_taken_cnt;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: table vectors, hand-written multi-cycle
// sequences and random stimulus against an operand-level reference model.

module tb_branch_redirect_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned FLUSH = 2;
  localparam int unsigned CNTW  = 4;
  localparam int          CMOD  = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ex_valid = 1'b0;
  logic [2:0]      ex_branch_type = 3'd0;
  logic            ex_jump = 1'b0;
  logic            zero = 1'b0, neg = 1'b0, c_out = 1'b0, over = 1'b0;
  logic [XLEN-1:0] ex_target = '0;
  logic            redirect_ready = 1'b0;
  logic            redirect_valid, flush_if, flush_id, ex_stall;
  logic [XLEN-1:0] redirect_pc;
  logic [CNTW-1:0] branch_count, taken_count;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(
    .XLEN         (XLEN),
    .FLUSH_CYCLES (FLUSH),
    .CNT_W        (CNTW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_branch_type (ex_branch_type),
    .ex_jump        (ex_jump),
    .zero           (zero),
    .neg            (neg),
    .c_out          (c_out),
    .over           (over),
    .ex_target      (ex_target),
    .redirect_ready (redirect_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_if       (flush_if),
    .flush_id       (flush_id),
    .ex_stall       (ex_stall),
    .branch_count   (branch_count),
    .taken_count    (taken_count)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: a pending redirect flag, remaining squash cycles, last PC, counters.
  bit              m_pend = 1'b0;
  int              m_sq = 0;
  logic [XLEN-1:0] m_pc = '0;
  int              m_bc = 0;
  int              m_tc = 0;

  // Outputs captured at the last sample point, for hand-written checks.
  logic            s_fi, s_fd, s_rv, s_st;
  logic [XLEN-1:0] s_pc;

  typedef struct {
    string      name;
    logic [2:0] ty;
    logic       j, z, n, c, o;
    logic       tk, cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic void alu_flags(input logic [31:0] a, input logic [31:0] b,
                                    output logic z, output logic n, output logic c,
                                    output logic o);
    logic [32:0] d;
    d = {1'b0, a} + {1'b0, ~b} + 33'd1;
    c = d[32];
    z = (d[31:0] == 32'd0);
    n = d[31];
    o = (a[31] != b[31]) && (d[31] != a[31]);
  endfunction

  function automatic logic ref_cond(input logic [2:0] ty, input logic [31:0] a,
                                    input logic [31:0] b);
    case (ty)
      3'd1:    return a == b;
      3'd2:    return a != b;
      3'd3:    return $signed(a) < $signed(b);
      3'd4:    return $signed(a) >= $signed(b);
      3'd5:    return a < b;
      3'd6:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Drives one cycle at posedge+1, compares at negedge, advances the model, returns at posedge+1.
  task automatic step(input logic v, input logic [2:0] ty, input logic j, input logic z,
                      input logic n, input logic c, input logic o, input logic [31:0] tgt,
                      input logic rdy, input logic exp_tk, input logic exp_cnt);
    bit idle;
    ex_valid = v; ex_branch_type = ty; ex_jump = j;
    zero = z; neg = n; c_out = c; over = o;
    ex_target = tgt; redirect_ready = rdy;
    @(negedge clk);
    idle = !m_pend && (m_sq == 0);
    check("flush_if", flush_if, idle ? exp_tk : 1'b1);
    check("flush_id", flush_id, idle & exp_tk);
    check("redirect_valid", redirect_valid, m_pend);
    check("ex_stall", ex_stall, m_pend);
    check("redirect_pc", redirect_pc, m_pc);
    check("branch_count", branch_count, m_bc);
    check("taken_count", taken_count, m_tc);
    s_fi = flush_if; s_fd = flush_id; s_rv = redirect_valid; s_st = ex_stall;
    s_pc = redirect_pc;
    if (idle) begin
      if (exp_cnt) m_bc = (m_bc + 1) % CMOD;
      if (exp_tk) begin
        m_tc   = (m_tc + 1) % CMOD;
        m_pc   = tgt & ~32'd1;
        m_pend = 1'b1;
      end
    end else if (m_pend) begin
      if (rdy) begin
        m_pend = 1'b0;
        m_sq   = FLUSH;
      end
    end else begin
      m_sq--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 3'd0, 1'b0, 0, 0, 0, 0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  // Assert reset at posedge+1 with a jump presented; everything must drop at once.
  task automatic do_reset();
    ex_valid = 1'b1; ex_jump = 1'b1; redirect_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    check("rst redirect_valid", redirect_valid, 1'b0);
    check("rst flush_if", flush_if, 1'b0);
    check("rst flush_id", flush_id, 1'b0);
    check("rst ex_stall", ex_stall, 1'b0);
    check("rst redirect_pc", redirect_pc, 32'h0);
    check("rst branch_count", branch_count, 4'h0);
    check("rst taken_count", taken_count, 4'h0);
    m_pend = 1'b0; m_sq = 0; m_pc = '0; m_bc = 0; m_tc = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ex_valid = 1'b0; ex_jump = 1'b0;
  endtask

  initial begin
    int bc0, tc0, rv_cycles, st_cycles;
    logic [31:0] a, b, tgt;
    logic [2:0] ty;
    logic v, j, z, n, c, o, cond;

    //           name          ty    j  z  n  c  o  tk cnt
    vecs[0] = '{"beq_eq",     3'd1, 0, 1, 0, 0, 0, 1, 1};
    vecs[1] = '{"beq_ne",     3'd1, 0, 0, 0, 1, 0, 0, 1};
    vecs[2] = '{"blt_n1_v1",  3'd3, 0, 0, 1, 0, 1, 0, 1};
    vecs[3] = '{"bge_n1_v0",  3'd4, 0, 0, 1, 0, 0, 0, 1};
    vecs[4] = '{"bltu_c0",    3'd5, 0, 0, 0, 0, 0, 1, 1};
    vecs[5] = '{"bgeu_c0",    3'd6, 0, 0, 0, 0, 0, 0, 1};
    vecs[6] = '{"bne_z0",     3'd2, 0, 0, 0, 1, 0, 1, 1};
    vecs[7] = '{"type7",      3'd7, 0, 1, 1, 1, 1, 0, 0};
    vecs[8] = '{"jal_type3",  3'd3, 1, 0, 0, 0, 0, 1, 1};
    vecs[9] = '{"none_type0", 3'd0, 0, 1, 0, 1, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Main flow: BEQ taken with immediate ready.
    step(1'b1, 3'd1, 1'b0, 1, 0, 1, 0, 32'h104, 1'b1, 1'b1, 1'b1);
    check("N flush_if", s_fi, 1'b1);
    check("N flush_id", s_fd, 1'b1);
    check("N redirect_valid", s_rv, 1'b0);
    idle_steps(1);
    check("N+1 redirect_valid", s_rv, 1'b1);
    check("N+1 redirect_pc", s_pc, 32'h104);
    check("N+1 flush_id", s_fd, 1'b0);
    idle_steps(1);
    check("N+2 flush_if", s_fi, 1'b1);
    check("N+2 redirect_valid", s_rv, 1'b0);
    idle_steps(1);
    check("N+3 flush_if", s_fi, 1'b1);
    idle_steps(1);
    check("N+4 flush_if", s_fi, 1'b0);
    check("flow branch_count", branch_count, 4'd1);
    check("flow taken_count", taken_count, 4'd1);

    // Decoder table.
    foreach (vecs[k]) begin
      bc0 = m_bc; tc0 = m_tc;
      step(1'b1, vecs[k].ty, vecs[k].j, vecs[k].z, vecs[k].n, vecs[k].c, vecs[k].o,
           32'h0000_0800 + 32'(k * 4), 1'b1, vecs[k].tk, vecs[k].cnt);
      check({vecs[k].name, " taken"}, s_fd, vecs[k].tk);
      idle_steps(4);
      check({vecs[k].name, " branch_count"}, branch_count, (bc0 + int'(vecs[k].cnt)) % CMOD);
      check({vecs[k].name, " taken_count"}, taken_count, (tc0 + int'(vecs[k].tk)) % CMOD);
    end

    // Backpressure, with taken-looking wrong-path instructions during REDIR/SQUASH.
    bc0 = m_bc; tc0 = m_tc; rv_cycles = 0; st_cycles = 0;
    step(1'b1, 3'd1, 1'b0, 1, 0, 1, 0, 32'h500, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'd1, 1'b0, 1, 0, 1, 0, 32'hdead_0000, (i == 3), 1'b1, 1'b1);
      rv_cycles += int'(s_rv);
      st_cycles += int'(s_st);
      check("bp redirect_pc stable", s_pc, 32'h500);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 3'd2, 1'b1, 0, 0, 1, 0, 32'hbeef_0000, 1'b1, 1'b1, 1'b1);
      rv_cycles += int'(s_rv);
    end
    idle_steps(1);
    check("bp valid cycles", rv_cycles, 4);
    check("bp stall cycles", st_cycles, 4);
    check("bp branch_count", branch_count, (bc0 + 1) % CMOD);
    check("bp taken_count", taken_count, (tc0 + 1) % CMOD);

    // JALR clears bit 0 only.
    tc0 = m_tc;
    step(1'b1, 3'd0, 1'b1, 0, 0, 0, 0, 32'h2003, 1'b1, 1'b1, 1'b1);
    idle_steps(1);
    check("jalr redirect_pc", s_pc, 32'h2002);
    idle_steps(3);
    check("jalr taken_count", taken_count, (tc0 + 1) % CMOD);

    // Reset mid-redirect, then IDLE must resolve immediately.
    step(1'b1, 3'd0, 1'b1, 0, 0, 0, 0, 32'h3000, 1'b0, 1'b1, 1'b1);
    idle_steps(0);
    step(1'b0, 3'd0, 1'b0, 0, 0, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 3'd0, 1'b1, 0, 0, 0, 0, 32'h3100, 1'b1, 1'b1, 1'b1);
    check("post-reset flush_id", s_fd, 1'b1);
    idle_steps(3);

    // Counter wrap with back-to-back jumps in the first IDLE cycle after SQUASH.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 3'd0, 1'b1, 0, 0, 0, 0, 32'h4000 + 32'(i * 8), 1'b1, 1'b1, 1'b1);
      idle_steps(3);
      if (i == 14) check("wrap bc at 15", branch_count, 4'd15);
    end
    check("wrap branch_count", branch_count, 4'd0);
    check("wrap taken_count", taken_count, 4'd0);

    // Random operands against the reference model.
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      b = ($urandom_range(3) == 0) ? a : $urandom;
      ty = 3'($urandom_range(7));
      j = ($urandom_range(7) == 0);
      v = ($urandom_range(3) != 0);
      tgt = $urandom;
      alu_flags(a, b, z, n, c, o);
      cond = ref_cond(ty, a, b);
      step(v, ty, j, z, n, c, o, tgt, 1'($urandom_range(1)), v & (j | cond),
           v & (j | (ty >= 3'd1 && ty <= 3'd6)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
